// File: rtl/rename_pkg.sv
// Shared types and constants for the rename-stage physical register free list.
// Tag 0 is permanently bound to architectural r0 and never enters the list.
package rename_pkg;

  localparam int NUM_PHY = 64;
  localparam int PHY_W   = 6;
  localparam int ALLOC_W = 4;
  localparam int SCAN_W  = 4;
  localparam int CNT_W   = 7;

  typedef logic [PHY_W-1:0] phy_tag_t;

  typedef enum logic {
    FL_IDLE    = 1'b0,
    FL_REBUILD = 1'b1
  } fl_state_t;

  localparam phy_tag_t               PHY_ZERO   = 6'd0;
  localparam logic [CNT_W-1:0]       CNT_MAX    = 7'd63;
  localparam logic [CNT_W-1:0]       RESET_FREE = 7'd32;
  localparam logic [NUM_PHY-1:0]     TAG0_BIT   = {{(NUM_PHY-1){1'b0}}, 1'b1};

  // Rebuild group (SCAN_W tags per group) that a tag belongs to
  function automatic logic [3:0] tag_group(input phy_tag_t tag);
    return tag[PHY_W-1:2];
  endfunction

endpackage

// File: rtl/phy_free_list_ctrl_if.sv
// Rename/commit/flush side signals of the physical free list.
// master = pipeline driving requests, slave = the free-list controller.
interface phy_free_list_ctrl_if;
  import rename_pkg::*;

  logic [ALLOC_W-1:0]       alloc_req;
  logic                     alloc_grant;
  logic [ALLOC_W*PHY_W-1:0] alloc_phy;
  logic                     alloc_stall;
  logic                     rel_valid;
  phy_tag_t                 rel_phy;
  logic                     flush;
  logic [NUM_PHY-1:0]       commit_used;
  logic                     recovering;
  logic [CNT_W-1:0]         free_count;
  logic                     fl_err;

  modport master (
    output alloc_req, rel_valid, rel_phy, flush, commit_used,
    input  alloc_grant, alloc_phy, alloc_stall, recovering, free_count, fl_err
  );

  modport slave (
    input  alloc_req, rel_valid, rel_phy, flush, commit_used,
    output alloc_grant, alloc_phy, alloc_stall, recovering, free_count, fl_err
  );

endinterface

// File: rtl/free_list_prefix.sv
// Exclusive prefix count of a 4-bit mask: per-bit offsets plus total popcount.
// Shared by slot-order allocation and rebuild compaction of free tags.
module free_list_prefix
  import rename_pkg::*;
(
  input  logic [SCAN_W-1:0]   mask,
  output logic [2*SCAN_W-1:0] offs,
  output logic [2:0]          pop
);

  logic [2:0] acc_s;

  // Running count of set bits below each position
  always_comb begin
    acc_s = 3'd0;
    offs  = {(2*SCAN_W){1'b0}};
    for (int i = 0; i < SCAN_W; i++) begin
      offs[2*i +: 2] = acc_s[1:0];
      acc_s          = acc_s + {2'b00, mask[i]};
    end
    pop = acc_s;
  end

endmodule

// File: rtl/phy_free_list_ctrl.sv
// Free-list manager for the 64-entry physical register file: 4-wide in-order
// allocation, commit reclaim, and a 16-cycle bitmap rebuild after a flush.
module phy_free_list_ctrl
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  phy_free_list_ctrl_if.slave bus
);

  phy_tag_t                 fifo_r [NUM_PHY];
  logic [CNT_W-1:0]         head_r;
  logic [CNT_W-1:0]         tail_r;
  logic [CNT_W-1:0]         count_r;
  fl_state_t                state_r;
  fl_state_t                state_s;
  logic [3:0]               scan_ptr_r;
  logic [NUM_PHY-1:0]       snap_r;
  logic                     fl_err_r;

  logic [2*ALLOC_W-1:0]     req_offs_s;
  logic [2:0]               req_pop_s;
  logic [SCAN_W-1:0]        zero_mask_s;
  logic [2*SCAN_W-1:0]      zero_offs_s;
  logic [2:0]               zero_pop_s;
  logic [NUM_PHY-1:0]       rel_onehot_s;
  logic [NUM_PHY-1:0]       snap_eff_s;
  logic                     rebuilding_s;
  logic                     rel_live_s;
  logic                     rel_zero_s;
  logic                     rel_defer_s;
  logic                     rel_full_s;
  logic                     rel_app_s;
  logic                     grant_s;
  logic [CNT_W-1:0]         alloc_n_s;
  logic [CNT_W-1:0]         grant_n_s;
  logic [CNT_W-1:0]         fill_s;
  logic [CNT_W-1:0]         fill_count_s;
  logic [ALLOC_W*PHY_W-1:0] phy_out_s;

  free_list_prefix u_req_prefix (
    .mask (bus.alloc_req),
    .offs (req_offs_s),
    .pop  (req_pop_s)
  );

  free_list_prefix u_scan_prefix (
    .mask (zero_mask_s),
    .offs (zero_offs_s),
    .pop  (zero_pop_s)
  );

  // Release routing; a release into a not-yet-scanned group is folded into the snapshot
  always_comb begin
    rebuilding_s = (state_r == FL_REBUILD) && !bus.flush;
    rel_live_s   = bus.rel_valid && (bus.rel_phy != PHY_ZERO);
    rel_zero_s   = bus.rel_valid && (bus.rel_phy == PHY_ZERO);
    rel_onehot_s = TAG0_BIT << bus.rel_phy;
    rel_defer_s  = rebuilding_s && rel_live_s && (tag_group(bus.rel_phy) >= scan_ptr_r);
    snap_eff_s   = rel_defer_s ? (snap_r & ~rel_onehot_s) : snap_r;
    zero_mask_s  = rebuilding_s ? ~snap_eff_s[{scan_ptr_r, 2'b00} +: SCAN_W] : {SCAN_W{1'b0}};
    fill_s       = CNT_W'(zero_pop_s);
    fill_count_s = count_r + fill_s;
    rel_full_s   = rel_live_s && !bus.flush && !rel_defer_s && (fill_count_s >= CNT_MAX);
    rel_app_s    = rel_live_s && !bus.flush && !rel_defer_s && (fill_count_s < CNT_MAX);
  end

  // All-or-nothing grant against the registered count; tags read from head in slot order
  always_comb begin
    alloc_n_s = CNT_W'(req_pop_s);
    grant_s   = (state_r == FL_IDLE) && !bus.flush && (req_pop_s != 3'd0) && (count_r >= alloc_n_s);
    grant_n_s = grant_s ? alloc_n_s : {CNT_W{1'b0}};
    phy_out_s = {(ALLOC_W*PHY_W){1'b0}};
    for (int i = 0; i < ALLOC_W; i++) begin
      if (grant_s && bus.alloc_req[i]) begin
        phy_out_s[PHY_W*i +: PHY_W] = fifo_r[PHY_W'(head_r + CNT_W'(req_offs_s[2*i +: 2]))];
      end else begin
        phy_out_s[PHY_W*i +: PHY_W] = PHY_ZERO;
      end
    end
  end

  // Next-state logic; a flush always (re)starts the rebuild
  always_comb begin
    state_s = state_r;
    case (state_r)
      FL_IDLE: begin
        if (bus.flush) state_s = FL_REBUILD;
        else           state_s = FL_IDLE;
      end
      FL_REBUILD: begin
        if (bus.flush)                 state_s = FL_REBUILD;
        else if (scan_ptr_r == 4'd15)  state_s = FL_IDLE;
        else                           state_s = FL_REBUILD;
      end
      default: state_s = FL_IDLE;
    endcase
  end

  // Pointers, count, scan position, snapshot and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FL_IDLE;
      head_r     <= 7'd0;
      tail_r     <= RESET_FREE;
      count_r    <= RESET_FREE;
      scan_ptr_r <= 4'd0;
      snap_r     <= {NUM_PHY{1'b0}};
      fl_err_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      fl_err_r <= fl_err_r | rel_zero_s | rel_full_s;
      if (bus.flush) begin
        head_r     <= 7'd0;
        tail_r     <= 7'd0;
        count_r    <= 7'd0;
        scan_ptr_r <= 4'd0;
        snap_r     <= (bus.commit_used | TAG0_BIT) & ~(rel_live_s ? rel_onehot_s : {NUM_PHY{1'b0}});
      end else begin
        head_r     <= head_r + grant_n_s;
        tail_r     <= tail_r + fill_s + CNT_W'(rel_app_s);
        count_r    <= count_r - grant_n_s + fill_s + CNT_W'(rel_app_s);
        scan_ptr_r <= rebuilding_s ? (scan_ptr_r + 4'd1) : scan_ptr_r;
        snap_r     <= snap_eff_s;
      end
    end
  end

  // Tag storage: scan appends first, then a direct release lands behind them
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHY; i++) begin
        fifo_r[i] <= (i < NUM_PHY/2) ? PHY_W'(i + NUM_PHY/2) : PHY_ZERO;
      end
    end else begin
      for (int j = 0; j < SCAN_W; j++) begin
        if (zero_mask_s[j]) begin
          fifo_r[PHY_W'(tail_r + CNT_W'(zero_offs_s[2*j +: 2]))] <= {scan_ptr_r, 2'(j)};
        end
      end
      if (rel_app_s) begin
        fifo_r[PHY_W'(tail_r + fill_s)] <= bus.rel_phy;
      end
    end
  end

  assign bus.alloc_grant = grant_s;
  assign bus.alloc_phy   = phy_out_s;
  assign bus.alloc_stall = (bus.alloc_req != 4'd0) && !grant_s;
  assign bus.recovering  = (state_r == FL_REBUILD);
  assign bus.free_count  = count_r;
  assign bus.fl_err      = fl_err_r;

endmodule

// File: doc/phy_free_list_ctrl.md
Name: phy_free_list_ctrl

Overview:
- Free-list manager and allocation scheduler for the 64-entry physical register file used by the 4-wide rename stage.
- Hands out up to 4 free physical tags per cycle to the rename slots, in slot order.
- Reclaims tags released by the commit unit.
- On branch flush, rebuilds the free list from the committed-mapping bitmap with a multi-cycle scan FSM.

Parameters:
- NUM_PHY, 64, physical registers; tag 0 is permanently bound to arch r0 and never allocated.
- PHY_W, 6, tag width.
- ALLOC_W, 4, rename slots per cycle.
- SCAN_W, 4, bitmap bits examined per rebuild cycle (NUM_PHY/SCAN_W = 16 cycles).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  4  per-slot request mask (bit i = slot i has RegW and is valid)
- alloc_grant  out  1  all requested slots served this cycle (all-or-nothing)
- alloc_phy  out  24  slot i tag at [6i+5:6i]; 0 for non-requesting slots
- alloc_stall  out  1  ~alloc_grant while alloc_req != 0
- rel_valid  in  1  commit frees a previous mapping
- rel_phy  in  6  tag being freed
- flush  in  1  branch flush, single-cycle pulse
- commit_used  in  64  bit p = 1 if tag p is held by committed map; sampled on flush
- recovering  out  1  rebuild FSM active
- free_count  out  7  registered number of free tags
- fl_err  out  1  sticky; release into full list, or release of tag 0

Behaviour:
- Storage: 64-entry circular FIFO of tags; head/tail are 7-bit (6-bit index + wrap bit); count register 7 bits.
- Reset: entries 0..31 = tags 32..63; head=0, tail=32, free_count=32; state IDLE; recovering=0; fl_err=0.
- Allocation is legal only in state IDLE with flush=0:
  - n = popcount(alloc_req).
  - alloc_grant = (free_count >= n) & (n != 0). Combinational, same cycle.
  - Requesting slots take FIFO[head+k] in ascending slot order, where k = number of lower-numbered requesting slots. Example: req=1010 gives slot1=FIFO[head], slot3=FIFO[head+1].
  - On grant, head advances by n at the next edge. No grant means no pointer change; tags stay valid combinationally for the retry.
- Release:
  - rel_valid with rel_phy != 0 writes FIFO[tail]; tail and count advance next edge.
  - A released tag is not allocatable in the same cycle, because grant uses the registered count.
  - A release with rel_phy == 0 is dropped and sets fl_err.
  - A release with free_count == 63 is dropped and sets fl_err.
- Same-cycle allocation and release: both take effect; count_next = count - n + 1.
- Flush, any state:
  - snapshot <= commit_used | bit0.
  - If rel_valid, clear snapshot[rel_phy] (merged release).
  - head=tail=0, count=0, scan_ptr=0, state=REBUILD.
  - No grant in the flush cycle.
- REBUILD, one group per cycle:
  - Examine snapshot[4*scan_ptr +: 4].
  - Append each zero bit's tag at tail in ascending order; tail and count increase by the number of zeros.
  - scan_ptr increments; after group 15, state becomes IDLE on the next edge.
  - Total: exactly 16 cycles from the cycle after flush.
- Release during REBUILD:
  - If the tag's group is >= scan_ptr, clear its snapshot bit; the scan appends it later.
  - Otherwise write it at tail after that cycle's scan appends (up to 5 writes per cycle).
- Flush during REBUILD: restart from scratch with a new snapshot.
- recovering = (state == REBUILD); alloc_grant is forced to 0 while recovering.
- Outputs:
  - alloc_phy is zeroed for non-requesting slots and whenever grant = 0.
  - free_count is registered and never exceeds 63.

Decomposition:
- Shared package rename_pkg:
  - PHY_W, NUM_PHY, ALLOC_W, SCAN_W.
  - typedef phy_tag_t (6 bits).
  - FSM enum fl_state_t {FL_IDLE, FL_REBUILD}.
  - Constant PHY_ZERO = 0.
- One sub-module, free_list_prefix: 4-bit mask in; per-slot offsets (2 bits each) and 3-bit popcount out; purely combinational.
  - Used for alloc_req slot offsets and for rebuild group-zero compaction.

Test Plan:
- Reset check: after rst, free_count=32 and recovering=0. Then alloc_req=1111 gives grant=1, alloc_phy slots = 32,33,34,35, and next-cycle free_count=28.
- Sparse slot order: after reset, alloc_req=1010 gives slot1=32, slot3=33, slots 0 and 2 = 0; head advances by 2.
- Stall and retry: drain to free_count=3, then alloc_req=1111 gives grant=0 and stall=1 with pointers unchanged. Add rel_valid (rel_phy=5) that cycle; next cycle free_count=4 and grant=1 with tag 5 last.
- Flush rebuild: commit_used = 0x00000000_FFFFFFFF with flush gives recovering=1 for 16 cycles and grant=0 throughout. The list then holds 32..63 in order; free_count=32.
- Release during rebuild: in cycle 2 of REBUILD, release tag 3 (group 0, already scanned, so appended directly) and tag 60 (group 15, snapshot cleared). Final free_count = base+2; both tags appear exactly once.
- Error and restart: rel_phy=0 sets fl_err, with count unchanged. A second flush mid-REBUILD restarts the scan; recovering stays high for 16 cycles from the second flush.
